// File: rtl/hazard_forward_scoreboard.sv
// Hazard unit: per-port forwarding selects, load-use / MUL-DIV stall, and a one-deep MUL/DIV countdown scoreboard.
// Optional stall statistic counter is built only when HAZ_STALL_STATS_EN is defined.
module hazard_forward_scoreboard #(
  parameter int AW             = 5,
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int MD_LATENCY     = 4,
  localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC*AW-1:0]       ex_src_addr,
  input  logic [NUM_FWD_STAGES*AW-1:0] stg_rd,
  input  logic [NUM_FWD_STAGES-1:0]   stg_regwrite,
  input  logic [NUM_SRC*AW-1:0]       id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_valid,
  input  logic                        id_md_op,
  input  logic [AW-1:0]               ex_rd,
  input  logic                        ex_memread,
  input  logic                        md_issue,
  input  logic [AW-1:0]               md_issue_rd,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall,
  output logic                        md_busy,
  output logic                        md_done,
  output logic [AW-1:0]               md_done_rd,
  output logic [31:0]                 stall_cycles
);

  localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [AW-1:0]        r_md_rd;
  logic [AW-1:0]        w_md_rd_nxt;

  logic                 w_md_busy;
  logic                 w_md_done;
  logic                 w_md_pending;
  logic                 w_load_use;
  logic                 w_md_raw;
  logic                 w_md_struct;
  logic                 w_stall;
  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;

  // Forwarding select: walk oldest to youngest so the youngest matching stage wins.
  always_comb begin
    w_fwd_sel = {(NUM_SRC*SEL_W){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
        w_fwd_sel[i*SEL_W +: SEL_W] =
          (stg_regwrite[k] &&
           (stg_rd[k*AW +: AW] != {AW{1'b0}}) &&
           (stg_rd[k*AW +: AW] == ex_src_addr[i*AW +: AW]))
          ? SEL_W'(k + 1) : w_fwd_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  assign fwd_sel = w_fwd_sel;

  assign w_md_busy    = (r_state == S_BUSY);
  assign w_md_done    = w_md_busy && (r_cnt == {CNT_W{1'b0}});
  // The done-cycle result is visible through write-before-read, so it no longer blocks readers.
  assign w_md_pending = w_md_busy && !w_md_done;

  // Stall terms: load-use, RAW on the MUL/DIV destination, and unit occupancy.
  always_comb begin
    w_load_use = 1'b0;
    w_md_raw   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_load_use = w_load_use |
        (ex_memread && (ex_rd != {AW{1'b0}}) && id_src_valid[i] &&
         (id_src_addr[i*AW +: AW] == ex_rd));
      w_md_raw = w_md_raw |
        (id_src_valid[i] && (id_src_addr[i*AW +: AW] != {AW{1'b0}}) &&
         ((w_md_pending && (id_src_addr[i*AW +: AW] == r_md_rd)) ||
          (md_issue && (id_src_addr[i*AW +: AW] == md_issue_rd))));
    end
    w_md_struct = id_md_op && (w_md_pending || md_issue);
    w_stall     = w_load_use | w_md_raw | w_md_struct;
  end

  assign stall = w_stall;

  // Scoreboard state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_md_rd <= {AW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_md_rd <= w_md_rd_nxt;
    end
  end

  // Scoreboard next state; an issue while the count is still running is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_md_rd_nxt = r_md_rd;
    case (r_state)
      S_IDLE: begin
        if (md_issue) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_LOAD;
          w_md_rd_nxt = md_issue_rd;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt != {CNT_W{1'b0}}) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (md_issue) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_LOAD;
          w_md_rd_nxt = md_issue_rd;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign md_busy    = w_md_busy;
  assign md_done    = w_md_done;
  assign md_done_rd = w_md_done ? r_md_rd : {AW{1'b0}};

`ifdef HAZ_STALL_STATS_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of stalled cycles, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
    end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
